// File: rtl/sm_pkg.sv
// Shared types and helpers for the stepper motion-profile sequencer.
// Period helpers saturate so ramp arithmetic never wraps.
package sm_pkg;

  localparam int unsigned SIZE_DEF   = 16;
  localparam int unsigned STEP_W_DEF = 16;
  localparam int unsigned PW_DEF     = SIZE_DEF + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    DONE   = 3'd4
  } sm_state_e;

  typedef logic [PW_DEF-1:0] period_t;

  // min(a + b, hi), computed one bit wider so the carry is never lost
  function automatic period_t sat_add(input period_t a, input period_t b, input period_t hi);
    logic [PW_DEF:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, hi}) ? hi : s[PW_DEF-1:0];
  endfunction

  // max(a - b, lo); a borrow out means the true result is negative
  function automatic period_t sat_sub(input period_t a, input period_t b, input period_t lo);
    logic [PW_DEF:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[PW_DEF] || (d[PW_DEF-1:0] < lo)) ? lo : d[PW_DEF-1:0];
  endfunction

endpackage

// File: rtl/sm_period_ramp.sv
// Current step period and ramp-step counter with load / speed-up / slow-down controls.
// Next-period values are exported so the sequencer can see them before committing.
module sm_period_ramp
  import sm_pkg::*;
#(
  parameter int unsigned SIZE   = SIZE_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic [SIZE:0]     i_load_val,
  input  logic [SIZE:0]     i_v_start,
  input  logic [SIZE:0]     i_v_min,
  input  logic [SIZE:0]     i_delta,
  output logic [SIZE:0]     o_period,
  output logic [SIZE:0]     o_acc_next_c,
  output logic [SIZE:0]     o_dec_next_c,
  output logic [STEP_W-1:0] o_ramp_cnt
);

  localparam int unsigned PW = SIZE + 1;

  logic [PW-1:0]     r_period;
  logic [STEP_W-1:0] r_ramp_cnt;

  assign o_acc_next_c = PW'(sat_sub(PW_DEF'(r_period), PW_DEF'(i_delta), PW_DEF'(i_v_min)));
  assign o_dec_next_c = PW'(sat_add(PW_DEF'(r_period), PW_DEF'(i_delta), PW_DEF'(i_v_start)));
  assign o_period     = r_period;
  assign o_ramp_cnt   = r_ramp_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period   <= '0;
      r_ramp_cnt <= '0;
    end else if (i_load) begin
      r_period   <= i_load_val;
      r_ramp_cnt <= '0;
    end else if (i_inc) begin
      r_period   <= o_acc_next_c;
      r_ramp_cnt <= r_ramp_cnt + STEP_W'(1);
    end else if (i_dec) begin
      r_period <= o_dec_next_c;
      if (r_ramp_cnt != '0) r_ramp_cnt <= r_ramp_cnt - STEP_W'(1);
    end
  end

endmodule

// File: rtl/sm_motion_ctrl.sv
// Trapezoidal/triangular motion sequencer: steps the pulse generator's period
// down, holds cruise, ramps back up and stops exactly on the commanded step count.
module sm_motion_ctrl
  import sm_pkg::*;
#(
  parameter int unsigned SIZE   = SIZE_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              dir_in,
  input  logic [STEP_W-1:0] target_steps,
  input  logic [SIZE:0]     v_start,
  input  logic [SIZE:0]     v_min,
  input  logic [SIZE:0]     delta,
  input  logic              step_fb,
  output logic [SIZE:0]     period_N,
  output logic              period_load,
  output logic              drv_enable,
  output logic              drv_dir,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned PW = SIZE + 1;

  sm_state_e         r_state, w_next_state;
  logic [STEP_W-1:0] r_rem;
  logic [PW-1:0]     r_v_start, r_v_min, r_delta;
  logic              r_period_load, r_drv_enable, r_drv_dir, r_busy, r_done, r_aborted;

  logic              w_active, w_accept, w_abort, w_step, w_next_active;
  logic              w_load, w_inc, w_dec;
  logic [STEP_W-1:0] w_rem_next, w_ramp_cnt;
  logic [PW-1:0]     w_period, w_acc_next, w_dec_next;

  assign w_active      = (r_state == ACCEL) || (r_state == CRUISE) || (r_state == DECEL);
  assign w_accept      = (r_state == IDLE) && start && !abort;
  assign w_abort       = w_active && abort;
  assign w_step        = w_active && !abort && step_fb;
  assign w_rem_next    = r_rem - STEP_W'(1);
  assign w_next_active = (w_next_state == ACCEL) || (w_next_state == CRUISE) ||
                         (w_next_state == DECEL);

  sm_period_ramp #(.SIZE(SIZE), .STEP_W(STEP_W)) u_ramp (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_inc        (w_inc),
    .i_dec        (w_dec),
    .i_load_val   (v_start),
    .i_v_start    (r_v_start),
    .i_v_min      (r_v_min),
    .i_delta      (r_delta),
    .o_period     (w_period),
    .o_acc_next_c (w_acc_next),
    .o_dec_next_c (w_dec_next),
    .o_ramp_cnt   (w_ramp_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next state and ramp controls; abort outranks a coincident step
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (target_steps == '0) begin
            w_next_state = DONE;
          end else begin
            w_load       = 1'b1;
            w_next_state = ((delta == '0) || (v_start <= v_min)) ? CRUISE : ACCEL;
          end
        end
      end
      ACCEL, CRUISE, DECEL: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (step_fb) begin
          if (w_rem_next == '0) begin
            w_next_state = DONE;
          end else if ((r_state != DECEL) && (w_rem_next <= w_ramp_cnt)) begin
            w_dec        = 1'b1;
            w_next_state = DECEL;
          end else if (r_state == ACCEL) begin
            w_inc = 1'b1;
            if (w_acc_next == r_v_min) w_next_state = CRUISE;
          end else if (r_state == DECEL) begin
            w_dec = 1'b1;
          end
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem         <= '0;
      r_v_start     <= '0;
      r_v_min       <= '0;
      r_delta       <= '0;
      r_period_load <= 1'b0;
      r_drv_enable  <= 1'b0;
      r_drv_dir     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rem     <= target_steps;
        r_v_start <= v_start;
        r_v_min   <= v_min;
        r_delta   <= delta;
        r_drv_dir <= dir_in;
      end else if (w_step) begin
        r_rem <= w_rem_next;
      end
      // A strobe only when the period word actually moves
      r_period_load <= w_load || (w_inc && (w_acc_next != w_period)) ||
                       (w_dec && (w_dec_next != w_period));
      r_drv_enable  <= w_next_active;
      r_busy        <= w_next_active;
      r_done        <= (w_next_state == DONE) || w_abort;
      if (w_accept)     r_aborted <= 1'b0;
      else if (w_abort) r_aborted <= 1'b1;
    end
  end

  assign period_N    = w_period;
  assign period_load = r_period_load;
  assign drv_enable  = r_drv_enable;
  assign drv_dir     = r_drv_dir;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;

endmodule

// File: doc/sm_motion_ctrl.md
Name: sm_motion_ctrl

Overview:
- Trapezoidal/triangular motion-profile sequencer for the stepper-motor pulse generator.
- Accepts a move command with step count, start period, cruise period and ramp delta.
- Drives the pulse generator's period word, period-load strobe and enable, and counts its step pulses to ramp the period down, hold, ramp up and stop exactly on the target step count.
- Sits between the host/command register block and the pulse generator.

Parameters:
SIZE, 16, period word is SIZE+1 bits, matching the pulse generator's N port
STEP_W, 16, width of the step-count command and internal step counters

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset, asynchronous, active-low; clears all state when 0
start  input  1  one-cycle move request; accepted only in IDLE
abort  input  1  immediate stop request; has priority over every other input
dir_in  input  1  move direction; latched on accepted start
target_steps  input  STEP_W  number of step pulses to emit
v_start  input  SIZE+1  start/stop period (slowest)
v_min  input  SIZE+1  cruise period (fastest)
delta  input  SIZE+1  period change applied per step while ramping
step_fb  input  1  drv_step from the pulse generator, one cycle per step
period_N  output  SIZE+1  period word to the pulse generator N input
period_load  output  1  one-cycle strobe to the pulse generator data_valid_trig; 1 whenever period_N takes a new value
drv_enable  output  1  to the pulse generator in_drv_enable_SM
drv_dir  output  1  latched direction
busy  output  1  high in ACCEL, CRUISE or DECEL
done  output  1  one-cycle pulse at move completion or abort
aborted  output  1  high with done when the move ended by abort; held until the next accepted start

Behaviour:
- Reset values (rst=0): state IDLE; period_N=0; period_load=0; drv_enable=0; drv_dir=0; busy=0; done=0; aborted=0; all counters 0.
- Internal registers: rem (STEP_W), ramp_cnt (STEP_W), cur_period (SIZE+1), latched v_start, v_min and delta.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.

IDLE, on start=1 and abort=0:
- Latch all command inputs: rem=target_steps, ramp_cnt=0, aborted=0.
- If target_steps==0: go to DONE. No enable and no load.
- Else: next cycle period_N=v_start, period_load=1, drv_enable=1.
  - If delta==0 or v_start<=v_min, go to CRUISE.
  - Otherwise go to ACCEL.
- Latency from start to drv_enable is 1 cycle.

On every step_fb in ACCEL, CRUISE or DECEL:
- rem_next=rem-1.
- If rem_next==0: go to DONE.
- Otherwise:
  - ACCEL or CRUISE with rem_next<=ramp_cnt: go to DECEL; period=min(period+delta, v_start); ramp_cnt saturating decrement.
  - ACCEL otherwise: period=max(period-delta, v_min), computed in SIZE+2 bits so underflow saturates to v_min; ramp_cnt+1. If the new period==v_min, go to CRUISE.
  - CRUISE otherwise: no change.
  - DECEL: period=min(period+delta, v_start); ramp_cnt saturating decrement.
- period_load=1 in the cycle after any period change; otherwise 0.

DONE (one cycle):
- drv_enable=0, done=1, then go to IDLE.
- period_N holds its last value.

Boundary and priority rules:
- abort in any active state: next cycle drv_enable=0, done=1, aborted=1, state IDLE. A coincident step_fb is ignored.
- abort in IDLE: no effect, and a coincident start is dropped.
- start while busy is ignored. step_fb in IDLE or DONE is ignored.
- Changes to command inputs after start have no effect.

Decomposition:
- Shared package sm_pkg: state enum (IDLE, ACCEL, CRUISE, DECEL, DONE), SIZE/STEP_W defaults, and saturating add/sub functions on SIZE+1 period words.
- One natural sub-module: sm_period_ramp, holding cur_period and ramp_cnt with inc/dec/load controls and saturation.

Test Plan:
- Trapezoid: steps=20, v_start=100, v_min=60, delta=10.
  - Period sequence 100,90,80,70,60 (CRUISE after step 4).
  - DECEL at step 16: 70,80,90,100.
  - DONE after step 20, with exactly 9 period_load pulses and done high for 1 cycle.
- Triangle: steps=4, same periods.
  - Periods 100,90,80, then DECEL at step 3 to 90, DONE after step 4.
  - CRUISE is never entered.
- Zero or flat moves:
  - steps=0: done 1 cycle after start; drv_enable and period_load never asserted.
  - delta=0, steps=5: period_N=100 constant, CRUISE only, done after 5th step_fb.
- Abort mid-CRUISE with coincident step_fb: next cycle drv_enable=0, done=1, aborted=1, IDLE; rem not decremented. A new start clears aborted.
- Robustness: start during busy, and step_fb while IDLE, both leave state unchanged.
- Async reset mid-ACCEL: rst=0 between clock edges clears all outputs immediately. After release, a new start is accepted normally.
